// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - initiator-side ALU sequencer with valid/ready request/response and shift-add MUL
module alu_seq_ctrl #(
    parameter int ALU_LAT = 0,
    parameter bit MUL_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    output logic [31:0] alu_A,
    output logic [31:0] alu_B,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_res,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_res,
    output logic        rsp_zero,
    output logic        rsp_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [1:0] LAT = 2'(ALU_LAT);

    state_t      r_state;
    state_t      w_next;
    // r_a doubles as the MUL multiplicand and r_b as the multiplier
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [2:0]  r_op;
    logic [31:0] r_acc;
    logic [1:0]  r_cnt;
    logic [31:0] r_res;
    logic        r_zero;
    logic        r_err;

    logic        w_is_mul;
    logic        w_legal;
    logic        w_step_end;
    logic        w_accept;

    assign w_is_mul   = MUL_EN && (cmd_op == 4'b1000);
    assign w_legal    = !cmd_op[3] || w_is_mul;
    assign w_step_end = (r_cnt == LAT);
    assign w_accept   = (r_state == S_IDLE) && cmd_valid;

    assign rsp_res  = r_res;
    assign rsp_zero = r_zero;
    assign rsp_err  = r_err;

    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = (r_state != S_IDLE);
        alu_A     = 32'd0;
        alu_B     = 32'd0;
        alu_op    = 3'd0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (!w_legal) begin
                        w_next = S_RESP;
                    end else if (w_is_mul) begin
                        w_next = S_MUL;
                    end else begin
                        w_next = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                alu_A  = r_a;
                alu_B  = r_b;
                alu_op = r_op;
                if (w_step_end) begin
                    w_next = S_RESP;
                end
            end
            S_MUL: begin
                if (r_b == 32'd0) begin
                    w_next = S_RESP;
                end else begin
                    alu_A  = r_acc;
                    alu_B  = r_a;
                    alu_op = 3'b010;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_op    <= 3'd0;
            r_acc   <= 32'd0;
            r_cnt   <= 2'd0;
            r_res   <= 32'd0;
            r_zero  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a   <= cmd_a;
                r_b   <= cmd_b;
                r_op  <= cmd_op[2:0];
                r_acc <= 32'd0;
                r_cnt <= 2'd0;
                if (!w_legal) begin
                    r_res  <= 32'd0;
                    r_zero <= 1'b1;
                    r_err  <= 1'b1;
                end
            end
            if (r_state == S_EXEC) begin
                if (w_step_end) begin
                    r_res  <= alu_res;
                    r_zero <= alu_zero;
                    r_err  <= 1'b0;
                    r_cnt  <= 2'd0;
                end else begin
                    r_cnt <= r_cnt + 2'd1;
                end
            end
            if (r_state == S_MUL) begin
                if (r_b == 32'd0) begin
                    r_res  <= r_acc;
                    r_zero <= (r_acc == 32'd0);
                    r_err  <= 1'b0;
                end else if (w_step_end) begin
                    // Partial product only joins the sum when the current multiplier bit is set
                    if (r_b[0]) begin
                        r_acc <= alu_res;
                    end
                    r_a   <= r_a << 1;
                    r_b   <= r_b >> 1;
                    r_cnt <= 2'd0;
                end else begin
                    r_cnt <= r_cnt + 2'd1;
                end
            end
        end
    end

endmodule
